// File: rtl/sensor_frontend.sv
// Conditions ADC samples (block average, frozen during save) and save/load buttons (debounced, held commands).
// Latency: average +1 edge after the last sample; command DEBOUNCE_CYCLES+2 edges after a press; no backpressure, samples never stall.
module sensor_frontend #(
    parameter int SAMPLE_W        = 12,
    parameter int AVG_LOG2        = 3,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 64
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    input  logic                save_btn,
    input  logic                load_btn,
    output logic [31:0]         sensor_input_to_save,
    output logic [31:0]         save_signal,
    output logic [31:0]         load_signal
);
    localparam int ACC_W  = SAMPLE_W + AVG_LOG2;
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [AVG_LOG2-1:0] CNT_LAST = '1;

    typedef enum logic [1:0] {IDLE, SAVE_HOLD, LOAD_HOLD} state_t;

    // Button index 0 is save, 1 is load.
    logic [1:0]           btn_raw;
    logic [1:0]           sync1_q, sync2_q;
    logic [1:0]           deb_q, deb_d, deb_prev_q;
    logic [1:0][DB_W-1:0] db_cnt_q, db_cnt_d;
    logic [1:0]           rise;

    state_t               state_q, state_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic                 frozen;

    logic [ACC_W-1:0]     acc_q, acc_d, sum;
    logic [AVG_LOG2-1:0]  cnt_q, cnt_d;
    logic [SAMPLE_W-1:0]  result_q, result_d;
    logic                 pend_q, pend_d;
    logic [31:0]          out_q, out_d;

    assign btn_raw = {load_btn, save_btn};
    assign rise    = deb_q & ~deb_prev_q;

    always_comb begin
        deb_d    = deb_q;
        db_cnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    // Edges arriving outside IDLE are simply not looked at, so they are dropped rather than queued.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (rise[0]) begin
                    state_d = SAVE_HOLD;
                    hold_d  = HOLD_W'(HOLD_CYCLES);
                end else if (rise[1]) begin
                    state_d = LOAD_HOLD;
                    hold_d  = HOLD_W'(HOLD_CYCLES);
                end
            end
            SAVE_HOLD, LOAD_HOLD: begin
                if (hold_q == HOLD_W'(1)) begin
                    state_d = IDLE;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                hold_d  = '0;
            end
        endcase
    end

    assign frozen = (state_q == SAVE_HOLD);
    assign sum    = acc_q + ACC_W'(sample_in);

    // result_q always holds the newest average; pend_q marks it as not yet published.
    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        pend_d   = pend_q;
        out_d    = out_q;
        if (pend_q && !frozen) begin
            out_d  = 32'(result_q);
            pend_d = 1'b0;
        end
        if (sample_valid) begin
            cnt_d = cnt_q + AVG_LOG2'(1);
            if (cnt_q == CNT_LAST) begin
                acc_d    = '0;
                result_d = SAMPLE_W'(sum >> AVG_LOG2);
                pend_d   = 1'b1;
            end else begin
                acc_d = sum;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            db_cnt_q   <= '0;
            state_q    <= IDLE;
            hold_q     <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            result_q   <= '0;
            pend_q     <= 1'b0;
            out_q      <= '0;
        end else begin
            sync1_q    <= btn_raw;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            db_cnt_q   <= db_cnt_d;
            state_q    <= state_d;
            hold_q     <= hold_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            pend_q     <= pend_d;
            out_q      <= out_d;
        end
    end

    assign sensor_input_to_save = out_q;
    assign save_signal          = {31'b0, state_q == SAVE_HOLD};
    assign load_signal          = {31'b0, state_q == LOAD_HOLD};

endmodule

// File: tb/tb_sensor_frontend.sv
// Randomized self-checking bench for sensor_frontend with a block-level behavioural reference.
module tb_sensor_frontend;
    localparam int SAMPLE_W = 12;
    localparam int AVG_N    = 8;
    localparam int DEB      = 16;
    localparam int HOLD     = 64;
    localparam int CMD_LAT  = DEB + 2;

    logic                clock;
    logic                reset;
    logic [SAMPLE_W-1:0] sample_in;
    logic                sample_valid;
    logic                save_btn;
    logic                load_btn;
    logic [31:0]         sensor_input_to_save;
    logic [31:0]         save_signal;
    logic [31:0]         load_signal;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] cur_out;

    sensor_frontend #(
        .SAMPLE_W        (SAMPLE_W),
        .AVG_LOG2        (3),
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_CYCLES     (HOLD)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .sample_in            (sample_in),
        .sample_valid         (sample_valid),
        .save_btn             (save_btn),
        .load_btn             (load_btn),
        .sensor_input_to_save (sensor_input_to_save),
        .save_signal          (save_signal),
        .load_signal          (load_signal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reset with buttons held and samples streaming; the held save then yields one command.
    task automatic test_reset();
        int rise_at = -1;
        int highs = 0;
        int load_hi = 0;
        reset = 1'b1; save_btn = 1'b1; load_btn = 1'b1; sample_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sample_in = SAMPLE_W'($urandom);
            tick();
            n_cmp++;
            if (sensor_input_to_save !== 32'd0 || save_signal !== 32'd0 || load_signal !== 32'd0) begin
                n_err++;
                $display("FAIL reset_outputs: out=%0d save=%0d load=%0d, expected all 0",
                         sensor_input_to_save, save_signal, load_signal);
            end
        end
        reset = 1'b0; sample_valid = 1'b0;
        // Edge 1 after release is the first to sample the buttons.
        for (int t = 1; t <= 140; t++) begin
            if (t == 31) begin save_btn = 1'b0; load_btn = 1'b0; end
            tick();
            if (save_signal === 32'd1) begin
                highs++;
                if (rise_at < 0) rise_at = t;
            end
            if (load_signal !== 32'd0) load_hi++;
        end
        n_cmp++;
        if (rise_at != 1 + CMD_LAT) begin
            n_err++;
            $display("FAIL reset_save_rise: rose at edge %0d, expected %0d", rise_at, 1 + CMD_LAT);
        end
        n_cmp++;
        if (highs != HOLD) begin
            n_err++;
            $display("FAIL reset_save_len: %0d cycles, expected %0d", highs, HOLD);
        end
        n_cmp++;
        if (load_hi != 0) begin
            n_err++;
            $display("FAIL reset_load_quiet: load high %0d cycles, expected 0", load_hi);
        end
        cur_out = 32'd0;
    endtask

    // Fixed blocks back-to-back, then random blocks with random idle gaps; model is sum/8 per block.
    task automatic test_average();
        bit          v_q[$];
        int          s_q[$];
        int          blk[$];
        int          sum;
        int          gap;
        bit          due = 0;
        logic [31:0] due_val = 0;
        int fixed [3][8] = '{'{10, 20, 30, 40, 50, 60, 70, 80},
                             '{4095, 4095, 4095, 4095, 4095, 4095, 4095, 4095},
                             '{1, 1, 1, 1, 1, 1, 1, 2}};
        for (int b = 0; b < 3; b++)
            for (int j = 0; j < AVG_N; j++) begin
                v_q.push_back(1'b1);
                s_q.push_back(fixed[b][j]);
            end
        for (int b = 0; b < 3; b++)
            for (int j = 0; j < AVG_N; j++) begin
                gap = $urandom_range(0, 2);
                repeat (gap) begin
                    v_q.push_back(1'b0);
                    s_q.push_back($urandom_range(0, 4095));
                end
                v_q.push_back(1'b1);
                s_q.push_back($urandom_range(0, 4095));
            end
        v_q.push_back(1'b0);
        s_q.push_back(0);
        foreach (v_q[i]) begin
            sample_valid = v_q[i];
            sample_in    = SAMPLE_W'(s_q[i]);
            tick();
            if (due) begin
                n_cmp++;
                if (sensor_input_to_save !== due_val) begin
                    n_err++;
                    $display("FAIL avg_value: got %0d, expected %0d", sensor_input_to_save, due_val);
                end
                cur_out = due_val;
                due = 0;
            end
            if (v_q[i]) begin
                blk.push_back(s_q[i]);
                if (blk.size() == AVG_N) begin
                    sum = 0;
                    foreach (blk[k]) sum += blk[k];
                    n_cmp++;
                    if (sensor_input_to_save !== cur_out) begin
                        n_err++;
                        $display("FAIL avg_latency: got %0d on the last-sample edge, expected still %0d",
                                 sensor_input_to_save, cur_out);
                    end
                    due_val = 32'(sum / AVG_N);
                    due = 1;
                    blk.delete();
                end
            end
        end
        sample_valid = 1'b0;
    endtask

    // Random short bounces, then a stable 30-cycle press: one command, DEB+2 edges after stable high.
    task automatic test_debounce_hold();
        bit sched[$];
        bit lvl = 1'b1;
        int w, k;
        int rise_at = -1;
        int highs = 0;
        int pulses = 0;
        int load_hi = 0;
        logic prev = 1'b0;
        while (sched.size() < 40) begin
            w = $urandom_range(1, 12);
            repeat (w) sched.push_back(lvl);
            lvl = ~lvl;
        end
        repeat (3) sched.push_back(1'b0);
        k = sched.size() + 1;
        repeat (30) sched.push_back(1'b1);
        for (int t = 1; t <= k + 140; t++) begin
            save_btn = (t - 1 < sched.size()) ? sched[t-1] : 1'b0;
            tick();
            if (save_signal === 32'd1) begin
                highs++;
                if (!prev) pulses++;
                if (rise_at < 0) rise_at = t;
            end
            prev = (save_signal === 32'd1);
            if (load_signal !== 32'd0) load_hi++;
        end
        n_cmp++;
        if (rise_at != k + CMD_LAT) begin
            n_err++;
            $display("FAIL deb_rise: rose at edge %0d, expected %0d", rise_at, k + CMD_LAT);
        end
        n_cmp++;
        if (pulses != 1) begin
            n_err++;
            $display("FAIL deb_pulses: %0d save pulses, expected 1", pulses);
        end
        n_cmp++;
        if (highs != HOLD) begin
            n_err++;
            $display("FAIL hold_len: %0d cycles, expected %0d", highs, HOLD);
        end
        n_cmp++;
        if (load_hi != 0) begin
            n_err++;
            $display("FAIL deb_load_quiet: load high %0d cycles, expected 0", load_hi);
        end
    endtask

    // Simultaneous press: save wins; a later load press accepted mid-hold never produces a command.
    task automatic test_priority();
        int s2 = $urandom_range(50, 60);
        int rise_at = -1;
        int highs = 0;
        int load_hi = 0;
        int overlap = 0;
        for (int t = 1; t <= 200; t++) begin
            save_btn = (t <= 30);
            load_btn = (t <= 30) || (t >= s2 && t < s2 + 30);
            tick();
            if (save_signal === 32'd1) begin
                highs++;
                if (rise_at < 0) rise_at = t;
            end
            if (load_signal !== 32'd0) load_hi++;
            if (save_signal !== 32'd0 && load_signal !== 32'd0) overlap++;
        end
        load_btn = 1'b0; save_btn = 1'b0;
        n_cmp++;
        if (rise_at != 1 + CMD_LAT) begin
            n_err++;
            $display("FAIL prio_save_rise: rose at edge %0d, expected %0d", rise_at, 1 + CMD_LAT);
        end
        n_cmp++;
        if (highs != HOLD) begin
            n_err++;
            $display("FAIL prio_save_len: %0d cycles, expected %0d", highs, HOLD);
        end
        n_cmp++;
        if (load_hi != 0) begin
            n_err++;
            $display("FAIL prio_load_ignored: load high %0d cycles, expected 0", load_hi);
        end
        n_cmp++;
        if (overlap != 0) begin
            n_err++;
            $display("FAIL prio_exclusive: both high %0d cycles, expected 0", overlap);
        end
    endtask

    // Two blocks complete during a save hold; output holds, then shows the newer (100) one edge after the drop.
    task automatic test_freeze();
        logic [31:0] old = cur_out;
        bit seen = 0;
        int drop_t = -1;
        int bad_hold = 0;
        bit checked_rel = 0;
        for (int t = 1; t <= 150; t++) begin
            save_btn     = (t <= 20);
            sample_valid = (t >= 30 && t < 38) || (t >= 40 && t < 48);
            sample_in    = (t < 40) ? SAMPLE_W'($urandom) : SAMPLE_W'(100);
            tick();
            if (save_signal === 32'd1) seen = 1;
            else if (seen && drop_t < 0) drop_t = t;
            if (drop_t < 0 || t == drop_t) begin
                if (sensor_input_to_save !== old) bad_hold++;
            end else if (t == drop_t + 1) begin
                checked_rel = 1;
                n_cmp++;
                if (sensor_input_to_save !== 32'd100) begin
                    n_err++;
                    $display("FAIL freeze_release: got %0d, expected 100", sensor_input_to_save);
                end
            end
        end
        sample_valid = 1'b0;
        n_cmp++;
        if (!checked_rel) begin
            n_err++;
            $display("FAIL freeze_hold_seen: save hold never ended within bound, expected one");
        end
        n_cmp++;
        if (bad_hold != 0) begin
            n_err++;
            $display("FAIL freeze_hold: output moved on %0d cycles, expected fixed at %0d", bad_hold, old);
        end
        cur_out = 32'd100;
    endtask

    // Reset at hold cycle 30 with a partial block in flight; held button re-triggers; next block averages cleanly.
    task automatic test_reset_mid_hold();
        int hcnt = 0;
        int rise_at = -1;
        int highs = 0;
        int sum = 0;
        int s;
        save_btn = 1'b1;
        for (int t = 1; t <= 120 && hcnt < 30; t++) begin
            sample_valid = (t >= 40 && t < 43);
            sample_in    = SAMPLE_W'($urandom);
            tick();
            if (save_signal === 32'd1) hcnt++;
        end
        sample_valid = 1'b0;
        n_cmp++;
        if (hcnt != 30) begin
            n_err++;
            $display("FAIL midhold_reach: saw %0d hold cycles, expected 30", hcnt);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++;
        if (save_signal !== 32'd0 || sensor_input_to_save !== 32'd0) begin
            n_err++;
            $display("FAIL midhold_reset: save=%0d out=%0d, expected 0 and 0", save_signal, sensor_input_to_save);
        end
        for (int t = 1; t <= 140; t++) begin
            if (t == 31) save_btn = 1'b0;
            tick();
            if (save_signal === 32'd1) begin
                highs++;
                if (rise_at < 0) rise_at = t;
            end
        end
        n_cmp++;
        if (rise_at != 1 + CMD_LAT || highs != HOLD) begin
            n_err++;
            $display("FAIL midhold_repress: rise edge %0d len %0d, expected %0d and %0d",
                     rise_at, highs, 1 + CMD_LAT, HOLD);
        end
        for (int j = 0; j < AVG_N; j++) begin
            s = $urandom_range(0, 4095);
            sum += s;
            sample_valid = 1'b1;
            sample_in    = SAMPLE_W'(s);
            tick();
        end
        sample_valid = 1'b0;
        n_cmp++;
        if (sensor_input_to_save !== 32'd0) begin
            n_err++;
            $display("FAIL midhold_avg_early: got %0d, expected 0", sensor_input_to_save);
        end
        tick();
        n_cmp++;
        if (sensor_input_to_save !== 32'(sum / AVG_N)) begin
            n_err++;
            $display("FAIL midhold_avg: got %0d, expected %0d", sensor_input_to_save, sum / AVG_N);
        end
    endtask

    initial begin
        reset = 1'b1; sample_in = '0; sample_valid = 1'b0; save_btn = 1'b0; load_btn = 1'b0;
        cur_out = 32'd0;
        test_reset();
        test_average();
        test_debounce_hold();
        test_priority();
        test_freeze();
        test_reset_mid_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
        $fatal(1);
    end

endmodule
